// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional misalignment check: define DMEM_ALIGN_CHECK_EN.
package dmem_pkg;
    localparam int DATA_W = 32;
    localparam int ADR_W = 32;
    localparam int CNT_W = 4;
    localparam int DEPTH_DEF = 256;
    localparam int LAT_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADR_W-1:0]  adr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    function automatic int idx_w(int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/dmem_word_array.sv
// Synchronous single-port word store; read registered with the write.
// Kept separate from the handshake FSM so a memory macro can replace it.
module dmem_word_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_DEF,
    parameter int IDX_W = idx_w(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end
endmodule

// File: rtl/dmem_responder.sv
// Handshaked fixed-latency data-memory responder, one request at a time.
// Define DMEM_ALIGN_CHECK_EN to flag accesses with adr[1:0] != 0.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_DEF,
    parameter int LATENCY = LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              WrEn,
    input  logic [ADR_W-1:0]  adr,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              ack,
    output logic [DATA_W-1:0] data_out,
    output logic              err
);
    localparam int IDX_W = idx_w(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_t            state;
    req_t              cur;
    logic [CNT_W-1:0]  cnt;
    logic              use_rd;
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] rdata;
    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              bad;
    logic              fire;
    logic              arr_we;

    // Upper address bits only feed the range check; no wrap-around.
    assign in_range = {2'b00, cur.adr[ADR_W-1:2]} < ADR_W'(DEPTH_WORDS);
    assign idx = cur.adr[IDX_W+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
    assign bad = !in_range || (cur.adr[1:0] != 2'b00);
`else
    logic unused_ok;
    assign unused_ok = ^cur.adr[1:0];
    assign bad = !in_range;
`endif

    assign fire = (state == BUSY) && (cnt == '0);
    assign arr_we = fire && cur.we && !bad;

    // Loads present the array read directly during RESP, then get held.
    assign data_out = use_rd ? rdata : dout_q;

    dmem_word_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W(IDX_W)
    ) u_array (
        .clk(clk),
        .we(arr_we),
        .idx(idx),
        .wdata(cur.wdata),
        .rdata(rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ready  <= 1'b1;
            ack    <= 1'b0;
            err    <= 1'b0;
            dout_q <= '0;
            use_rd <= 1'b0;
            cnt    <= '0;
            cur    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        cur.we    <= WrEn;
                        cur.adr   <= adr;
                        cur.wdata <= data_in;
                        cnt       <= CNT_INIT;
                        state     <= BUSY;
                        ready     <= 1'b0;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state <= RESP;
                        ack   <= 1'b1;
                        err   <= bad;
                        if (!cur.we) begin
                            use_rd <= !bad;
                            if (bad) begin
                                dout_q <= '0;
                            end
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    ack    <= 1'b0;
                    ready  <= 1'b1;
                    use_rd <= 1'b0;
                    if (use_rd) begin
                        dout_q <= rdata;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    ack   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four instances at latencies 2, 1, 5, 3.
// Honours DMEM_ALIGN_CHECK_EN for the alignment scenario.
module tb_dmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  rst_n;
    logic [3:0]  req;
    logic [3:0]  wr_en;
    logic [3:0]  ready;
    logic [3:0]  ack;
    logic [3:0]  err;
    logic [31:0] adr [4];
    logic [31:0] data_in [4];
    logic [31:0] data_out [4];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          d;
        logic [31:0] data;
        logic        e;
        bit          chk;
    } exp_t;

    exp_t sb[$];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int L = (g == 0) ? 2 : (g == 1) ? 1 :
                           (g == 2) ? 5 : 3;
        dmem_responder #(
            .DEPTH_WORDS(256),
            .LATENCY(L)
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n[g]),
            .req(req[g]),
            .WrEn(wr_en[g]),
            .adr(adr[g]),
            .data_in(data_in[g]),
            .ready(ready[g]),
            .ack(ack[g]),
            .data_out(data_out[g]),
            .err(err[g])
        );
    end

    function automatic int lat(int d);
        return (d == 0) ? 2 : (d == 1) ? 1 : (d == 2) ? 5 : 3;
    endfunction

    task automatic issue(input int d, input logic we,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] xd, input logic xe,
                         input bit chk);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (ready[d] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait dut%0d: ready=%b required 1",
                     d, ready[d]);
        end
        req[d] = 1'b1;
        wr_en[d] = we;
        adr[d] = a;
        data_in[d] = wd;
        e.d = d;
        e.data = xd;
        e.e = xe;
        e.chk = chk;
        sb.push_back(e);
        @(posedge clk);
        #1 req[d] = 1'b0;
    endtask

    task automatic wait_ack(input int d, output int n);
        bit got;
        exp_t e;
        n = 0;
        got = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (ack[d] === 1'b1) begin
                got = 1;
                break;
            end
            checks++;
            if (ready[d] !== 1'b0) begin
                errors++;
                $display("FAIL ready_busy dut%0d: ready=%b required 0",
                         d, ready[d]);
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout dut%0d: no ack in %0d edges",
                     d, n);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (got) begin
                checks++;
                if (err[d] !== e.e) begin
                    errors++;
                    $display("FAIL err dut%0d: err=%b required %b",
                             d, err[d], e.e);
                end
                if (e.chk) begin
                    checks++;
                    if (data_out[d] !== e.data) begin
                        errors++;
                        $display("FAIL data dut%0d: got %h required %h",
                                 d, data_out[d], e.data);
                    end
                end
                @(negedge clk);
                checks++;
                if (ack[d] !== 1'b0 || ready[d] !== 1'b1) begin
                    errors++;
                    $display("FAIL ack_end dut%0d: ack=%b ready=%b required 0 1",
                             d, ack[d], ready[d]);
                end
            end
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (ready[d] !== 1'b1 || ack[d] !== 1'b0 ||
                err[d] !== 1'b0 || data_out[d] !== 32'h0) begin
                errors++;
                $display("FAIL reset dut%0d: rdy=%b ack=%b err=%b dout=%h required 1 0 0 0",
                         d, ready[d], ack[d], err[d], data_out[d]);
            end
        end
    endtask

    task automatic test_store_load();
        int n;
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
        wait_ack(0, n);
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL store_lat: %0d edges required 2", n);
        end
        issue(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1);
        wait_ack(0, n);
    endtask

    task automatic test_latency();
        int n;
        logic [31:0] v;
        for (int d = 0; d < 3; d++) begin
            v = 32'hA500_0000 + d;
            issue(d, 1'b1, 32'h40, v, 32'h0, 1'b0, 0);
            wait_ack(d, n);
            issue(d, 1'b0, 32'h40, 32'h0, v, 1'b0, 1);
            wait_ack(d, n);
            checks++;
            if (n !== lat(d)) begin
                errors++;
                $display("FAIL latency dut%0d: %0d edges required %0d",
                         d, n, lat(d));
            end
        end
    endtask

    task automatic test_back_to_back_ignore();
        int n;
        issue(0, 1'b1, 32'h20, 32'h1111, 32'h0, 1'b0, 0);
        @(negedge clk);
        req[0] = 1'b1;
        wr_en[0] = 1'b1;
        adr[0] = 32'h20;
        data_in[0] = 32'h2222;
        @(posedge clk);
        #1 req[0] = 1'b0;
        wait_ack(0, n);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (ack[0] !== 1'b0) begin
                errors++;
                $display("FAIL extra_ack: ack=%b required 0", ack[0]);
            end
        end
        issue(0, 1'b0, 32'h20, 32'h0, 32'h1111, 1'b0, 1);
        wait_ack(0, n);
    endtask

    task automatic test_out_of_range();
        int n;
        issue(0, 1'b1, 32'h400, 32'h5555, 32'h0, 1'b1, 0);
        wait_ack(0, n);
        issue(0, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 1);
        wait_ack(0, n);
        issue(0, 1'b1, 32'h0, 32'h12345678, 32'h0, 1'b0, 0);
        wait_ack(0, n);
        issue(0, 1'b0, 32'h0, 32'h0, 32'h12345678, 1'b0, 1);
        wait_ack(0, n);
        issue(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1, 1);
        wait_ack(0, n);
    endtask

    task automatic test_reset_midop();
        int n;
        exp_t e;
        issue(3, 1'b1, 32'h30, 32'h0, 32'h0, 1'b0, 0);
        wait_ack(3, n);
        issue(3, 1'b1, 32'h30, 32'hAAAA, 32'h0, 1'b0, 0);
        e = sb.pop_back();
        @(posedge clk);
        #1 rst_n[3] = 1'b0;
        #1;
        checks++;
        if (ready[3] !== 1'b1 || ack[3] !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset: ready=%b ack=%b required 1 0",
                     ready[3], ack[3]);
        end
        @(posedge clk);
        #1 rst_n[3] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (ack[3] !== 1'b0) begin
                errors++;
                $display("FAIL midop_ack: ack=%b required 0", ack[3]);
            end
        end
        issue(3, 1'b0, 32'h30, 32'h0, 32'h0, 1'b0, 1);
        wait_ack(3, n);
    endtask

    task automatic test_align();
        int n;
`ifdef DMEM_ALIGN_CHECK_EN
        issue(0, 1'b1, 32'h12, 32'hCAFEF00D, 32'h0, 1'b1, 0);
        wait_ack(0, n);
        issue(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1);
        wait_ack(0, n);
`else
        issue(0, 1'b1, 32'h12, 32'hCAFEF00D, 32'h0, 1'b0, 0);
        wait_ack(0, n);
        issue(0, 1'b0, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0, 1);
        wait_ack(0, n);
`endif
    endtask

    initial begin
        rst_n = '0;
        req = '0;
        wr_en = '0;
        for (int d = 0; d < 4; d++) begin
            adr[d] = '0;
            data_in[d] = '0;
        end
        repeat (3) @(negedge clk);
        rst_n = '1;
        @(negedge clk);
        test_reset();
        test_store_load();
        test_latency();
        test_back_to_back_ignore();
        test_out_of_range();
        test_reset_midop();
        test_align();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: %0d entries required 0",
                     sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
